exp_time_ctrl_gen2: RTL and testbench

Parametrised exposure-time controller for the pixel-array digital control path; successor to the fixed 5-bit exposure counter.
- Holds a user-adjustable exposure setting, changed by increase/decrease buttons while the main FSM is in IDLE.
- Runs a separate countdown during EXPOSURE, so the setting survives each exposure.
- Flags exposure completion with a one-cycle pulse that the main FSM uses to advance to READOUT.

---
 rtl/exp_time_ctrl_gen2.sv | 156 +++++++++++++++
 tb/tb_exp_time_ctrl_gen2.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/exp_time_ctrl_gen2.sv
// rtl/exp_time_ctrl_gen2.sv - parametrised exposure-time controller (setting, countdown, done pulse)
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Reset_n      asynchronous active-low reset
//   i_Main_FSM     main FSM state: 00 IDLE, 01 EXPOSURE, 10/11 READOUT
//   i_Exp_increase increase button level (already synchronised)
//   i_Exp_decrease decrease button level (already synchronised)
//   o_exp_setting  current exposure setting
//   o_count_time   remaining exposure cycles
//   o_exp_done     one-cycle pulse when a full exposure completes
//   o_exp_active   high while the countdown is running
//
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat of the buttons in IDLE).

module exp_time_ctrl_gen2 #(
    parameter int WIDTH        = 5,
    parameter int MIN_TIME     = 2,
    parameter int MAX_TIME     = 30,
    parameter int DEF_TIME     = 2,
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic [1:0]       i_Main_FSM,
    input  logic             i_Exp_increase,
    input  logic             i_Exp_decrease,
    output logic [WIDTH-1:0] o_exp_setting,
    output logic [WIDTH-1:0] o_count_time,
    output logic             o_exp_done,
    output logic             o_exp_active
);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_EXPOSURE = 2'b01;

    // Arithmetic runs one bit wider than the setting so saturation never wraps.
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MIN_W  = (WIDTH+1)'(MIN_TIME);
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_TIME);

    if (!(MIN_TIME >= 1 && MIN_TIME <= DEF_TIME && DEF_TIME <= MAX_TIME &&
          MAX_TIME <= (1 << WIDTH) - 1 && STEP >= 1 &&
          REPEAT_RATE >= 1 && REPEAT_RATE <= REPEAT_DELAY)) begin : g_param_error
        $error("exp_time_ctrl_gen2: illegal parameter combination");
    end

    logic [WIDTH-1:0] setting_q, setting_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             active_q, active_d;
    logic             inc_prev, dec_prev;
    logic             inc_edge, dec_edge;
    logic             do_inc, do_dec;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_limit;

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          repeat_step;
`endif

    always_comb begin
        inc_edge  = i_Exp_increase & ~inc_prev;
        dec_edge  = i_Exp_decrease & ~dec_prev;
        inc_sum   = {1'b0, setting_q} + STEP_W;
        dec_limit = MIN_W + STEP_W;
`ifdef AUTO_REPEAT_EN
        repeat_step = 1'b0;
        hold_d      = '0;
        if (i_Main_FSM == ST_IDLE) begin
            if (inc_edge || dec_edge) begin
                hold_d = HW'(1);
            end else if ((i_Exp_increase || i_Exp_decrease) && hold_q != '0) begin
                // hold_q != 0 means this hold began with an accepted edge in IDLE
                if (hold_q == HW'(REPEAT_DELAY)) begin
                    repeat_step = 1'b1;
                    hold_d      = HW'(REPEAT_DELAY - REPEAT_RATE + 1);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end
        do_inc = inc_edge | (repeat_step & i_Exp_increase);
        do_dec = ~do_inc & (dec_edge | (repeat_step & ~i_Exp_increase & i_Exp_decrease));
`else
        do_inc = inc_edge;
        do_dec = ~inc_edge & dec_edge;
`endif

        setting_d = setting_q;
        count_d   = count_q;
        done_d    = 1'b0;
        active_d  = 1'b0;

        case (i_Main_FSM)
            ST_IDLE: begin
                if (do_inc) begin
                    setting_d = (inc_sum > MAX_W) ? MAX_W[WIDTH-1:0] : inc_sum[WIDTH-1:0];
                end else if (do_dec) begin
                    setting_d = ({1'b0, setting_q} < dec_limit) ? MIN_W[WIDTH-1:0]
                                                                : setting_q - STEP_W[WIDTH-1:0];
                end
                count_d = setting_d;
            end
            ST_EXPOSURE: begin
                if (count_q != '0) begin
                    count_d  = count_q - WIDTH'(1);
                    active_d = 1'b1;
                    done_d   = (count_q == WIDTH'(1));
                end
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            setting_q <= WIDTH'(DEF_TIME);
            count_q   <= '0;
            done_q    <= 1'b0;
            active_q  <= 1'b0;
            inc_prev  <= 1'b0;
            dec_prev  <= 1'b0;
        end else begin
            setting_q <= setting_d;
            count_q   <= count_d;
            done_q    <= done_d;
            active_q  <= active_d;
            // Sampled in every state so a press held across EXPOSURE/READOUT is not re-counted.
            inc_prev  <= i_Exp_increase;
            dec_prev  <= i_Exp_decrease;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign o_exp_setting = setting_q;
    assign o_count_time  = count_q;
    assign o_exp_done    = done_q;
    assign o_exp_active  = active_q;

endmodule

// File: tb/tb_exp_time_ctrl_gen2.sv
// tb/tb_exp_time_ctrl_gen2.sv - directed self-checking bench for exp_time_ctrl_gen2

module tb_exp_time_ctrl_gen2;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm;
    logic       inc;
    logic       dec;
    logic [4:0] setting;
    logic [4:0] count;
    logic       done;
    logic       active;

    int checks   = 0;
    int failures = 0;

    exp_time_ctrl_gen2 dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_Main_FSM     (fsm),
        .i_Exp_increase (inc),
        .i_Exp_decrease (dec),
        .o_exp_setting  (setting),
        .o_count_time   (count),
        .o_exp_done     (done),
        .o_exp_active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1; step();
            inc = 1'b0; step();
        end
    endtask

    task automatic pulse_dec(input int n);
        for (int i = 0; i < n; i++) begin
            dec = 1'b1; step();
            dec = 1'b0; step();
        end
    endtask

    function automatic int hold_expect(input int i);
`ifdef AUTO_REPEAT_EN
        if (i >= 17) return 14;
        if (i >= 13) return 13;
        if (i >= 9)  return 12;
        return 11;
`else
        return 11;
`endif
    endfunction

    initial begin
        rst_n = 1'b0;
        fsm   = 2'b00;
        inc   = 1'b0;
        dec   = 1'b0;

        // Reset state
        step(); step();
        check("rst_setting", setting, 2);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_active", active, 0);
        rst_n = 1'b1;
        #2;
        check("post_rst_count_before_edge", count, 0);
        step();
        check("idle_count_loaded", count, 2);

        // Saturation
        pulse_inc(1);
        check("inc_one", setting, 3);
        pulse_inc(39);
        check("inc_sat_setting", setting, 30);
        check("inc_sat_count", count, 30);
        pulse_dec(1);
        check("dec_one", setting, 29);
        pulse_dec(39);
        check("dec_sat_setting", setting, 2);
        check("dec_sat_count", count, 2);

        // Simultaneous press at 10
        pulse_inc(8);
        check("reach_10", setting, 10);
        inc = 1'b1; dec = 1'b1; step();
        check("both_inc_wins", setting, 11);
        inc = 1'b0; dec = 1'b0; step();
        check("both_release", setting, 11);

        // Exposure with setting 5
        pulse_dec(6);
        check("reach_5", setting, 5);
        check("reach_5_count", count, 5);
        fsm = 2'b01;
        for (int c = 4; c >= 1; c--) begin
            step();
            check("exp_count", count, c);
            check("exp_done_low", done, 0);
            check("exp_active", active, 1);
            inc = (c == 3);
        end
        inc = 1'b0;
        step();
        check("exp_count_zero", count, 0);
        check("exp_done_pulse", done, 1);
        step();
        check("exp_done_once", done, 0);
        check("exp_active_end", active, 0);
        check("exp_count_stay", count, 0);
        check("exp_setting_frozen", setting, 5);

        // Abort
        fsm = 2'b00; step();
        check("reload_count", count, 5);
        fsm = 2'b01; step(); step();
        check("abort_count3", count, 3);
        fsm = 2'b10; step();
        check("abort_count0", count, 0);
        check("abort_no_done", done, 0);
        check("abort_setting", setting, 5);
        fsm = 2'b01; step();
        check("direct_exp_count", count, 0);
        check("direct_exp_active", active, 0);
        check("direct_exp_done", done, 0);
        step();
        check("direct_exp_done2", done, 0);

        // Asynchronous reset mid-exposure
        fsm = 2'b00; step();
        fsm = 2'b01; step();
        check("pre_rst_count", count, 4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_setting", setting, 2);
        check("async_rst_count", count, 0);
        check("async_rst_active", active, 0);
        check("async_rst_done", done, 0);
        step();
        rst_n = 1'b1;
        fsm = 2'b00;
        step();
        check("after_rst_count", count, 2);

        // Hold increase from 10 for 20 cycles
        pulse_inc(8);
        check("hold_start", setting, 10);
        inc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1 || i == 8 || i == 9 || i == 12 || i == 13 || i == 17 || i == 20)
                check($sformatf("hold_cycle_%0d", i), setting, hold_expect(i));
        end
        inc = 1'b0;
        step();
        check("hold_release", setting, hold_expect(20));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
